// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared types and bus select codes for the internal bus arbiter
package bus_arbiter_pkg;

  localparam int SEL_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_XFER   = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_e;

  // Bus mux source codes; R0..R15 map directly onto codes 0..15
  localparam logic [SEL_W-1:0] SEL_R0  = 5'd0,  SEL_R1  = 5'd1,  SEL_R2  = 5'd2,  SEL_R3  = 5'd3;
  localparam logic [SEL_W-1:0] SEL_R4  = 5'd4,  SEL_R5  = 5'd5,  SEL_R6  = 5'd6,  SEL_R7  = 5'd7;
  localparam logic [SEL_W-1:0] SEL_R8  = 5'd8,  SEL_R9  = 5'd9,  SEL_R10 = 5'd10, SEL_R11 = 5'd11;
  localparam logic [SEL_W-1:0] SEL_R12 = 5'd12, SEL_R13 = 5'd13, SEL_R14 = 5'd14, SEL_R15 = 5'd15;
  localparam logic [SEL_W-1:0] SEL_HI  = 5'd16, SEL_LO  = 5'd17, SEL_ZHI = 5'd18, SEL_ZLO = 5'd19;
  localparam logic [SEL_W-1:0] SEL_PC  = 5'd20, SEL_MDR = 5'd21, SEL_PORT = 5'd22, SEL_CSIGN = 5'd23;

endpackage

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - requester/arbiter handshake and bus drive signals
interface bus_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int DST_W = 24
) ();

  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       lock;
  logic [NREQ*5-1:0]     src_sel;
  logic [NREQ*DST_W-1:0] dst_ld;
  logic [NREQ-1:0]       gnt;
  logic [4:0]            bus_sel;
  logic [DST_W-1:0]      bus_ld;
  logic                  busy;
  logic                  err;

  modport master (
    output req, lock, src_sel, dst_ld,
    input  gnt, bus_sel, bus_ld, busy, err
  );

  modport slave (
    input  req, lock, src_sel, dst_ld,
    output gnt, bus_sel, bus_ld, busy, err
  );

endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// rtl/bus_arbiter_rr_picker.sv - combinational round-robin winner selection
module bus_arbiter_rr_picker #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  win_o,
  output logic [PW-1:0] idx_o,
  output logic          valid_o
);

  // Walk from the pointer upward (wrapping) and take the first active request
  always_comb begin
    int pos;
    pos     = 0;
    win_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      pos = int'(ptr_i) + k;
      if (pos >= N) pos = pos - N;
      for (int i = 0; i < N; i++) begin
        if (!valid_o && (i == pos) && req_i[i]) begin
          valid_o  = 1'b1;
          idx_o    = PW'(i);
          win_o[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin internal bus arbiter with locked bursts (optional BUS_ARB_STATS_EN counters)
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DST_W   = 24,
  parameter int MAX_SRC = 23
) (
  input  logic          clock,
  input  logic          clear_n,
  bus_arbiter_if.slave  bus
`ifdef BUS_ARB_STATS_EN
  ,
  output logic [31:0]   xfer_cnt,
  output logic [15:0]   err_cnt
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e        state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DST_W-1:0]  ld_q, ld_d;
  logic              err_q, err_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     idx_q, idx_d;

  logic [NREQ-1:0]   pick_win;
  logic [PW-1:0]     pick_idx;
  logic              pick_valid;

  logic              hold;
  logic              win_v;
  logic [NREQ-1:0]   win_oh;
  logic [PW-1:0]     win_idx;
  logic [SEL_W-1:0]  src_w;
  logic [DST_W-1:0]  dst_w;
  logic              legal;

  bus_arbiter_rr_picker #(
    .N  (NREQ),
    .PW (PW)
  ) u_picker (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .win_o   (pick_win),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // Next state: keep a locked legal winner, otherwise rearbitrate; then qualify the winner's request
  always_comb begin
    state_d = ST_IDLE;
    gnt_d   = '0;
    sel_d   = '0;
    ld_d    = '0;
    err_d   = 1'b0;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    hold    = 1'b0;
    win_v   = 1'b0;
    win_oh  = '0;
    win_idx = idx_q;
    src_w   = '0;
    dst_w   = '0;
    legal   = 1'b0;

    case (state_q)
      ST_IDLE, ST_XFER, ST_LOCKED: begin
        // An illegal transfer never starts or extends a burst
        hold = (state_q != ST_IDLE) && !err_q && (|(gnt_q & bus.req & bus.lock));
        if (hold) begin
          win_v   = 1'b1;
          win_oh  = gnt_q;
          win_idx = idx_q;
          state_d = ST_LOCKED;
        end else if (pick_valid) begin
          win_v   = 1'b1;
          win_oh  = pick_win;
          win_idx = pick_idx;
          state_d = ST_XFER;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (win_v) begin
      for (int i = 0; i < NREQ; i++) begin
        if (PW'(i) == win_idx) begin
          src_w = bus.src_sel[i*SEL_W +: SEL_W];
          dst_w = bus.dst_ld[i*DST_W +: DST_W];
        end
      end
      legal = (int'(src_w) <= MAX_SRC) && (dst_w != '0) &&
              ((dst_w & (dst_w - DST_W'(1))) == '0);
      gnt_d = win_oh;
      idx_d = win_idx;
      ptr_d = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
      if (legal) begin
        sel_d = src_w;
        ld_d  = dst_w;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // State and registered bus drive; reset clears everything immediately
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ld_q    <= '0;
      err_q   <= 1'b0;
      ptr_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ld_q    <= ld_d;
      err_q   <= err_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.bus_sel = sel_q;
  assign bus.bus_ld  = ld_q;
  assign bus.err     = err_q;
  assign bus.busy    = (|gnt_q) && !err_q;

`ifdef BUS_ARB_STATS_EN
  logic [31:0] xfer_cnt_q;
  logic [15:0] err_cnt_q;

  // Count each cycle a legal transfer is driven and each error pulse (error count saturates)
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      xfer_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (bus.busy) xfer_cnt_q <= xfer_cnt_q + 32'd1;
      if (err_q && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign xfer_cnt = xfer_cnt_q;
  assign err_cnt  = err_cnt_q;
`endif

endmodule
